// File: rtl/cyp_pkg.sv
// cyp_pkg: scheduler state encodings and slave-FIFO endpoint addresses.
package cyp_pkg;
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RX_ADDR  = 3'd1;
   localparam logic [2:0] S_RX_BURST = 3'd2;
   localparam logic [2:0] S_TX_ADDR  = 3'd3;
   localparam logic [2:0] S_TX_BURST = 3'd4;
   localparam logic [2:0] S_TURN     = 3'd5;
   localparam logic [1:0] EP2_ADDR   = 2'b00;
   localparam logic [1:0] EP6_ADDR   = 2'b10;
   localparam logic       G_RX       = 1'b0;
   localparam logic       G_TX       = 1'b1;
endpackage

// File: rtl/cyp_rr_arb2.sv
// cyp_rr_arb2: 2-way round-robin picker; bit0 = RX, bit1 = TX, last_grant 1 = TX.
module cyp_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);
   assign grant[0] = req[0] & (!req[1] | last_grant);
   assign grant[1] = req[1] & (!req[0] | !last_grant);
endmodule

// File: rtl/cyp_sfifo_sched.sv
// cyp_sfifo_sched: packet-granular RX/TX scheduler for the CY68013 slave-FIFO bus.
module cyp_sfifo_sched
   import cyp_pkg::*;
#(
   parameter int         PKT_WORDS = 256,
   parameter int         TURN_CLKS = 4,
   parameter logic [1:0] EP_RX     = EP2_ADDR,
   parameter logic [1:0] EP_TX     = EP6_ADDR
) (
   input  logic        cyp_clk,
   input  logic        rst,
   input  logic        usb_flaga,
   input  logic        usb_flagc,
   input  logic [15:0] usb_fd_i,
   output logic [15:0] usb_fd_o,
   output logic        usb_fd_oe,
   output logic [1:0]  usb_fifoaddr,
   output logic        usb_slcs,
   output logic        usb_sloe,
   output logic        usb_slrd,
   output logic        usb_slwr,
   output logic        usb_pktend,
   input  logic        rx_en,
   input  logic        rx_full,
   output logic        rx_wen,
   output logic [15:0] rx_wdata,
   input  logic        tx_rdy,
   output logic        tx_ren,
   input  logic [15:0] tx_rdata,
   output logic        rx_pkt_done,
   output logic        tx_pkt_done,
   output logic        busy
);
   localparam int WW = $clog2(PKT_WORDS);
   localparam int TW = $clog2(TURN_CLKS + 1);
   logic [2:0]    state;
   logic [WW-1:0] word_cnt;
   logic [TW-1:0] turn_cnt;
   logic          last_grant;
   logic [1:0]    grant;
   logic          rd_go, wr_go, last_word;
   cyp_rr_arb2 u_arb (
      .req        ({tx_rdy & usb_flagc, rx_en & usb_flaga & !rx_full}),
      .last_grant (last_grant),
      .grant      (grant)
   );
   assign rd_go        = (state == S_RX_BURST) & usb_flaga & !rx_full;
   assign wr_go        = (state == S_TX_BURST) & usb_flagc;
   assign last_word    = word_cnt == WW'(PKT_WORDS - 1);
   assign usb_slrd     = !rd_go;
   assign usb_slwr     = !wr_go;
   assign rx_wen       = rd_go;
   assign tx_ren       = wr_go;
   assign usb_sloe     = !((state == S_RX_ADDR) | (state == S_RX_BURST));
   assign usb_fd_oe    = (state == S_TX_ADDR) | (state == S_TX_BURST);
   assign usb_fd_o     = tx_rdata;
   assign rx_wdata     = usb_fd_i;
   assign usb_slcs     = 1'b0;
   assign usb_pktend   = 1'b1;
   assign busy         = state != S_IDLE;
   always_ff @(posedge cyp_clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         word_cnt     <= '0;
         turn_cnt     <= '0;
         last_grant   <= G_TX;
         usb_fifoaddr <= EP_RX;
         rx_pkt_done  <= 1'b0;
         tx_pkt_done  <= 1'b0;
      end else begin
         rx_pkt_done <= rd_go & last_word;
         tx_pkt_done <= wr_go & last_word;
         case (state)
            S_IDLE: if (|grant) begin
               last_grant   <= grant[1];
               usb_fifoaddr <= grant[1] ? EP_TX : EP_RX;
               state        <= grant[1] ? S_TX_ADDR : S_RX_ADDR;
            end
            S_RX_ADDR: state <= S_RX_BURST;
            S_TX_ADDR: state <= S_TX_BURST;
            S_RX_BURST, S_TX_BURST: if (rd_go | wr_go) begin
               word_cnt <= last_word ? '0 : word_cnt + 1'b1;
               turn_cnt <= '0;
               if (last_word) state <= S_TURN;
            end
            S_TURN: begin
               word_cnt <= '0;
               turn_cnt <= (turn_cnt == TW'(TURN_CLKS - 1)) ? '0 : turn_cnt + 1'b1;
               if (turn_cnt == TW'(TURN_CLKS - 1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cyp_sfifo_sched.sv
// tb_cyp_sfifo_sched: directed vectors and corner sequences for the slave-FIFO scheduler.
module tb_cyp_sfifo_sched;
   localparam int TURN_CLKS = 4;
   logic        cyp_clk = 1'b0, rst = 1'b0;
   logic        usb_flaga = 1'b0, usb_flagc = 1'b0, rx_en = 1'b0, rx_full = 1'b0, tx_rdy = 1'b0;
   logic [15:0] usb_fd_i = 16'h1000, tx_rdata = 16'h8000;
   logic [15:0] usb_fd_o, rx_wdata;
   logic [1:0]  usb_fifoaddr;
   logic        usb_fd_oe, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
   logic        rx_wen, tx_ren, rx_pkt_done, tx_pkt_done, busy;
   int checks = 0, errors = 0;
   int n_rd, n_wen, n_wr, n_ren, n_rdone, n_tdone, n_oe, n_sloe, n_rstall, n_wstall;
   int idle_run, gap_min, gap_max;
   bit seen_strobe;
   logic [7:0] ord;
   typedef struct {
      string      nm;
      bit         en, fa, full, tr, fc;
      logic [1:0] addr;
      int         rd, wr, rdone, tdone, oe, sloe;
   } vec_t;
   vec_t v[7];
   cyp_sfifo_sched #(.PKT_WORDS(256), .TURN_CLKS(TURN_CLKS)) dut (
      .cyp_clk(cyp_clk), .rst(rst), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
      .usb_fd_i(usb_fd_i), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
      .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
      .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
      .rx_en(rx_en), .rx_full(rx_full), .rx_wen(rx_wen), .rx_wdata(rx_wdata),
      .tx_rdy(tx_rdy), .tx_ren(tx_ren), .tx_rdata(tx_rdata),
      .rx_pkt_done(rx_pkt_done), .tx_pkt_done(tx_pkt_done), .busy(busy)
   );
   always #5 cyp_clk = ~cyp_clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic clr();
      n_rd = 0; n_wen = 0; n_wr = 0; n_ren = 0; n_rdone = 0; n_tdone = 0;
      n_oe = 0; n_sloe = 0; n_rstall = 0; n_wstall = 0;
      idle_run = 0; gap_min = 9999; gap_max = 0; seen_strobe = 0; ord = '0;
   endtask
   // Sample at negedge (what the next posedge acts on), drive new inputs just after posedge.
   task automatic tick();
      @(negedge cyp_clk);
      if (!usb_slrd) n_rd++;
      if (rx_wen) n_wen++;
      if (!usb_slwr) n_wr++;
      if (tx_ren) n_ren++;
      if (usb_fd_oe) n_oe++;
      if (!usb_sloe) n_sloe++;
      if (!usb_sloe && usb_slrd) n_rstall++;
      if (usb_fd_oe && usb_slwr) n_wstall++;
      if (rx_pkt_done) begin n_rdone++; ord = {ord[6:0], 1'b0}; end
      if (tx_pkt_done) begin n_tdone++; ord = {ord[6:0], 1'b1}; end
      chk("bus_excl", {30'd0, !usb_slrd && !usb_slwr, usb_fd_oe && !usb_sloe}, 32'd0);
      if (rx_wen) chk("rx_wdata", {16'd0, rx_wdata}, {16'd0, usb_fd_i});
      if (tx_ren) chk("fd_o", {16'd0, usb_fd_o}, {16'd0, tx_rdata});
      if (!usb_slrd || !usb_slwr) begin
         if (seen_strobe && idle_run > 0) begin
            if (idle_run < gap_min) gap_min = idle_run;
            if (idle_run > gap_max) gap_max = idle_run;
         end
         seen_strobe = 1;
         idle_run = 0;
      end else idle_run++;
      @(posedge cyp_clk);
      #1;
      usb_fd_i = usb_fd_i + 16'd3;
      tx_rdata = tx_rdata + 16'd1;
   endtask
   task automatic drop();
      rx_en = 0; usb_flaga = 0; rx_full = 0; tx_rdy = 0; usb_flagc = 0;
   endtask
   task automatic do_reset();
      drop();
      rst = 1;
      #1;
      chk("rst_out", {19'd0, usb_fifoaddr, usb_slrd, usb_slwr, usb_sloe, usb_fd_oe, rx_wen, tx_ren,
                      rx_pkt_done, tx_pkt_done, busy, usb_slcs, usb_pktend},
          {19'd0, 2'b00, 3'b111, 7'b0000000, 1'b1});
      tick(); tick();
      rst = 0;
      clr();
   endtask
   task automatic wait_done(input int target, input int lim);
      for (int c = 0; c < lim && (n_rdone + n_tdone) < target; c++) tick();
   endtask
   initial begin
      v[0] = '{"rx_only",  1, 1, 0, 0, 0, 2'b00, 256,   0, 1, 0,   0, 257};
      v[1] = '{"tx_only",  0, 0, 0, 1, 1, 2'b10,   0, 256, 0, 1, 257,   0};
      v[2] = '{"rx_dis",   0, 1, 0, 0, 0, 2'b00,   0,   0, 0, 0,   0,   0};
      v[3] = '{"rx_full",  1, 1, 1, 0, 0, 2'b00,   0,   0, 0, 0,   0,   0};
      v[4] = '{"tx_nospc", 0, 0, 0, 1, 0, 2'b00,   0,   0, 0, 0,   0,   0};
      v[5] = '{"tie_rx1",  1, 1, 0, 1, 1, 2'b00, 256,   0, 1, 0,   0, 257};
      v[6] = '{"tx_noflg", 1, 0, 0, 1, 1, 2'b10,   0, 256, 0, 1, 257,   0};
      for (int i = 0; i < 7; i++) begin
         do_reset();
         rx_en = v[i].en; usb_flaga = v[i].fa; rx_full = v[i].full;
         tx_rdy = v[i].tr; usb_flagc = v[i].fc;
         wait_done(1, 300);
         drop();
         repeat (8) tick();
         chk({v[i].nm, "_rd"},    n_rd,    v[i].rd);
         chk({v[i].nm, "_wen"},   n_wen,   v[i].rd);
         chk({v[i].nm, "_wr"},    n_wr,    v[i].wr);
         chk({v[i].nm, "_ren"},   n_ren,   v[i].wr);
         chk({v[i].nm, "_rdone"}, n_rdone, v[i].rdone);
         chk({v[i].nm, "_tdone"}, n_tdone, v[i].tdone);
         chk({v[i].nm, "_oe"},    n_oe,    v[i].oe);
         chk({v[i].nm, "_sloe"},  n_sloe,  v[i].sloe);
         chk({v[i].nm, "_addr"},  {30'd0, usb_fifoaddr}, {30'd0, v[i].addr});
         chk({v[i].nm, "_busy"},  {31'd0, busy}, 32'd0);
      end
      // Both paths always ready: strict alternation with a fixed turnaround gap.
      do_reset();
      rx_en = 1; usb_flaga = 1; tx_rdy = 1; usb_flagc = 1;
      wait_done(4, 1500);
      drop();
      repeat (8) tick();
      chk("rr_order", {24'd0, ord}, 32'h05);
      chk("rr_rd", n_rd, 512);
      chk("rr_wr", n_wr, 512);
      chk("rr_gap_min", gap_min, TURN_CLKS + 2);
      chk("rr_gap_max", gap_max, TURN_CLKS + 2);
      // rx_full stall at word 100 for 10 clocks.
      do_reset();
      rx_en = 1; usb_flaga = 1;
      for (int c = 0; c < 300 && n_rd < 100; c++) tick();
      begin
         int s0;
         s0 = n_rstall;
         rx_full = 1;
         repeat (10) tick();
         chk("rxstall_hi", n_rstall - s0, 10);
         chk("rxstall_rd", n_rd, 100);
         chk("rxstall_wen", n_wen, 100);
      end
      rx_full = 0;
      wait_done(1, 300);
      drop();
      repeat (8) tick();
      chk("rxstall_total", n_rd, 256);
      chk("rxstall_wen_total", n_wen, 256);
      chk("rxstall_done", n_rdone, 1);
      // flagc drop at word 200 for 20 clocks.
      do_reset();
      tx_rdy = 1; usb_flagc = 1;
      for (int c = 0; c < 300 && n_wr < 200; c++) tick();
      begin
         int s0;
         s0 = n_wstall;
         usb_flagc = 0;
         repeat (20) tick();
         chk("txstall_hi", n_wstall - s0, 20);
         chk("txstall_wr", n_wr, 200);
         chk("txstall_ren", n_ren, 200);
      end
      usb_flagc = 1;
      wait_done(1, 300);
      drop();
      repeat (8) tick();
      chk("txstall_total", n_wr, 256);
      chk("txstall_ren_total", n_ren, 256);
      chk("txstall_done", n_tdone, 1);
      // Reset mid-burst at RX word 50, then a fresh full packet.
      do_reset();
      rx_en = 1; usb_flaga = 1;
      for (int c = 0; c < 300 && n_rd < 50; c++) tick();
      chk("midrst_pre", n_rd, 50);
      rst = 1;
      #1;
      chk("midrst_out", {28'd0, usb_slrd, usb_sloe, rx_wen, busy}, {28'd0, 4'b1100});
      tick(); tick();
      rst = 0;
      clr();
      wait_done(1, 300);
      drop();
      repeat (8) tick();
      chk("midrst_rd", n_rd, 256);
      chk("midrst_done", n_rdone, 1);
      chk("midrst_addr", {30'd0, usb_fifoaddr}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
